// File: rtl/serial_magnitude_comparator.sv
// Sequential MSB-first magnitude comparator: DIGIT bits per clock, unsigned or
// two's-complement ordering, optional early exit on the first differing digit.
module serial_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              diff_q, diff_d;
    logic              lt_int_q, lt_int_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

    logic [DIGIT-1:0]  dig_a_s, dig_b_s;
    logic              diff_now_s, fin_diff_s, fin_lt_s, finish_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        lt_int_d = lt_int_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;

        dig_a_s    = sa_q[WIDTH-1 -: DIGIT];
        dig_b_s    = sb_q[WIDTH-1 -: DIGIT];
        // Once a difference is recorded, later digits cannot change the order
        diff_now_s = (!diff_q) && (dig_a_s != dig_b_s);
        fin_diff_s = diff_q | diff_now_s;
        fin_lt_s   = diff_q ? lt_int_q : (dig_a_s < dig_b_s);
        finish_s   = ((EARLY_EXIT != 0) && diff_now_s) || (cnt_q == '0);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Flipping both sign bits maps signed order onto unsigned order
                    sa_d     = signed_mode ? (a ^ MSB_MASK) : a;
                    sb_d     = signed_mode ? (b ^ MSB_MASK) : b;
                    cnt_d    = CNT_LAST;
                    diff_d   = 1'b0;
                    lt_int_d = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b0;
                    gt_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    sa_d  = sa_q << DIGIT;
                    sb_d  = sb_q << DIGIT;
                    cnt_d = cnt_q - CW'(1);
                    if (diff_now_s) begin
                        diff_d   = 1'b1;
                        lt_int_d = dig_a_s < dig_b_s;
                    end else begin
                        diff_d   = diff_q;
                        lt_int_d = lt_int_q;
                    end
                    if (finish_s) begin
                        lt_d    = fin_diff_s & fin_lt_s;
                        gt_d    = fin_diff_s & ~fin_lt_s;
                        eq_d    = ~fin_diff_s;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                lt_d    = 1'b0;
                eq_d    = 1'b0;
                gt_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            diff_q   <= 1'b0;
            lt_int_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            lt_int_q <= lt_int_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;

endmodule
